// File: rtl/mux_4_1_arb_v_if.sv
// Handshake bundle between four producers, the arbitrating mux and one consumer.
// The slave modport is the mux side; the master modport is the producer/consumer side.
interface mux_4_1_arb_v_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          i_valid;
    logic [4*DATA_W-1:0] i_data;
    logic [3:0]          o_ready;
    logic                o_valid;
    logic [DATA_W-1:0]   o_data;
    logic [3:0]          o_sel_code;
    logic                i_ready;
    logic [7:0]          o_count;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_sel_code, o_count
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_sel_code, o_count
    );
endinterface

// File: rtl/mux_4_1_arb_v.sv
// Four-to-one round-robin arbitrating mux with a registered output stage
// and a one-hot source tag for routing responses back through a deMUX.
module mux_4_1_arb_v #(
    parameter int DATA_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    mux_4_1_arb_v_if.slave  bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [3:0]          sel_q, sel_d;
    logic [7:0]          count_q, count_d;

    logic [1:0]          grant_idx;
    logic                grant_hit;
    logic [1:0]          cand;
    logic [3:0]          grant_oh;
    logic                load;
    logic                deliver;

    // Scan ptr+1, ptr+2, ptr+3, then ptr itself; the 2-bit sum wraps mod 4.
    always_comb begin
        grant_idx = '0;
        grant_hit = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!grant_hit && bus.i_valid[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_oh = 4'b0001 << grant_idx;
    assign load     = !i_rst && ((state_q == EMPTY) || bus.i_ready) && grant_hit;
    assign deliver  = (state_q == FULL) && bus.i_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        count_d = deliver ? count_q + 8'd1 : count_q;
        if (load) begin
            state_d = FULL;
            ptr_d   = grant_idx;
            data_d  = bus.i_data[grant_idx*DATA_W +: DATA_W];
            sel_d   = grant_oh;
        end else if (deliver) begin
            state_d = EMPTY;
            sel_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd3;
            data_q  <= '0;
            sel_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            count_q <= count_d;
        end
    end

    assign bus.o_ready    = load ? grant_oh : 4'b0000;
    assign bus.o_valid    = (state_q == FULL);
    assign bus.o_data     = data_q;
    assign bus.o_sel_code = sel_q;
    assign bus.o_count    = count_q;
endmodule

// File: tb/tb_mux_4_1_arb_v.sv
// Directed bench for mux_4_1_arb_v: inputs change and outputs are sampled on the falling edge.
module tb_mux_4_1_arb_v;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    mux_4_1_arb_v_if #(.DATA_W(8)) bus ();

    mux_4_1_arb_v #(.DATA_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_data(input int k, input logic [7:0] v);
        bus.i_data[k*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_valid = 4'b0000;
        bus.i_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_valid = 4'b1111;
        bus.i_ready = 1'b1;
        bus.i_data  = 32'hA3A2A1A0;
        #1;
        tests++; if (bus.o_ready !== 4'b0000) begin fails++; $display("FAIL rst_ready got=%b exp=0000", bus.o_ready); end
        step();
        step();
        tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", bus.o_valid); end
        tests++; if (bus.o_data !== 8'h00) begin fails++; $display("FAIL rst_data got=%h exp=00", bus.o_data); end
        tests++; if (bus.o_sel_code !== 4'b0000) begin fails++; $display("FAIL rst_sel got=%b exp=0000", bus.o_sel_code); end
        tests++; if (bus.o_count !== 8'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", bus.o_count); end
        rst = 1'b0;
        bus.i_valid = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            #1;
            tests++; if (bus.o_ready !== 4'b0000) begin fails++; $display("FAIL idle_ready cyc=%0d got=%b exp=0000", i, bus.o_ready); end
            step();
            tests++;
            if (bus.o_valid !== 1'b0 || bus.o_sel_code !== 4'b0000 || bus.o_count !== 8'd0) begin
                fails++;
                $display("FAIL idle_out cyc=%0d got v=%b sel=%b cnt=%0d exp v=0 sel=0000 cnt=0",
                         i, bus.o_valid, bus.o_sel_code, bus.o_count);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d;
        logic [3:0] exp_s;
        do_reset();
        bus.i_data  = 32'hA3A2A1A0;
        bus.i_valid = 4'b1111;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_s = 4'b0001 << (k % 4);
            exp_d = 8'hA0 + 8'(k % 4);
            #1;
            tests++; if (bus.o_ready !== exp_s) begin fails++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, bus.o_ready, exp_s); end
            step();
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== exp_d || bus.o_sel_code !== exp_s) begin
                fails++;
                $display("FAIL rr_out k=%0d got v=%b d=%h sel=%b exp v=1 d=%h sel=%b",
                         k, bus.o_valid, bus.o_data, bus.o_sel_code, exp_d, exp_s);
            end
        end
        bus.i_valid = 4'b0000;
        step();
        tests++; if (bus.o_count !== 8'd8) begin fails++; $display("FAIL rr_count got=%0d exp=8", bus.o_count); end
        tests++; if (bus.o_valid !== 1'b0 || bus.o_sel_code !== 4'b0000) begin fails++; $display("FAIL rr_drain got v=%b sel=%b exp v=0 sel=0000", bus.o_valid, bus.o_sel_code); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.i_data  = 32'h0;
        set_data(2, 8'h5C);
        bus.i_valid = 4'b0100;
        bus.i_ready = 1'b0;
        #1;
        tests++; if (bus.o_ready !== 4'b0100) begin fails++; $display("FAIL bp_accept got=%b exp=0100", bus.o_ready); end
        step();
        // Other channels request during the stall; none of them may be consumed.
        bus.i_valid = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (bus.o_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", i, bus.o_ready); end
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h5C || bus.o_sel_code !== 4'b0100) begin
                fails++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h sel=%b exp v=1 d=5c sel=0100",
                         i, bus.o_valid, bus.o_data, bus.o_sel_code);
            end
            step();
        end
        bus.i_valid = 4'b0000;
        bus.i_ready = 1'b1;
        step();
        step();
        tests++; if (bus.o_count !== 8'd1) begin fails++; $display("FAIL bp_count got=%0d exp=1", bus.o_count); end
        tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got=%b exp=0", bus.o_valid); end
    endtask

    task automatic test_priority_stall();
        do_reset();
        bus.i_data  = 32'hB3B2B1B0;
        bus.i_valid = 4'b0010;
        bus.i_ready = 1'b0;
        step();
        bus.i_valid = 4'b0000;
        step();
        step();
        step();
        tests++; if (bus.o_sel_code !== 4'b0010) begin fails++; $display("FAIL ps_stall_sel got=%b exp=0010", bus.o_sel_code); end
        bus.i_valid = 4'b1010;
        bus.i_ready = 1'b1;
        #1;
        tests++; if (bus.o_ready !== 4'b1000) begin fails++; $display("FAIL ps_grant1 got=%b exp=1000", bus.o_ready); end
        step();
        tests++; if (bus.o_data !== 8'hB3 || bus.o_sel_code !== 4'b1000) begin fails++; $display("FAIL ps_out1 got d=%h sel=%b exp d=b3 sel=1000", bus.o_data, bus.o_sel_code); end
        bus.i_valid = 4'b0010;
        #1;
        tests++; if (bus.o_ready !== 4'b0010) begin fails++; $display("FAIL ps_grant2 got=%b exp=0010", bus.o_ready); end
        step();
        tests++; if (bus.o_data !== 8'hB1 || bus.o_sel_code !== 4'b0010) begin fails++; $display("FAIL ps_out2 got d=%h sel=%b exp d=b1 sel=0010", bus.o_data, bus.o_sel_code); end
        bus.i_valid = 4'b0000;
        step();
        tests++; if (bus.o_count !== 8'd3) begin fails++; $display("FAIL ps_count got=%0d exp=3", bus.o_count); end
    endtask

    task automatic test_single();
        do_reset();
        bus.i_data  = 32'h0;
        bus.i_valid = 4'b1000;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_data(3, 8'hC0 + 8'(k));
            #1;
            tests++; if (bus.o_ready !== 4'b1000) begin fails++; $display("FAIL single_ready k=%0d got=%b exp=1000", k, bus.o_ready); end
            step();
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== 8'hC0 + 8'(k) || bus.o_sel_code !== 4'b1000) begin
                fails++;
                $display("FAIL single_out k=%0d got v=%b d=%h sel=%b exp v=1 d=%h sel=1000",
                         k, bus.o_valid, bus.o_data, bus.o_sel_code, 8'hC0 + 8'(k));
            end
        end
        bus.i_valid = 4'b0000;
        step();
        tests++; if (bus.o_count !== 8'd5) begin fails++; $display("FAIL single_count got=%0d exp=5", bus.o_count); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        bus.i_data  = 32'h0;
        bus.i_valid = 4'b0001;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            set_data(0, 8'(k));
            step();
        end
        tests++; if (bus.o_count !== 8'd255) begin fails++; $display("FAIL wrap_255 got=%0d exp=255", bus.o_count); end
        set_data(0, 8'hEE);
        step();
        tests++; if (bus.o_count !== 8'd0) begin fails++; $display("FAIL wrap_0 got=%0d exp=0", bus.o_count); end
        tests++; if (bus.o_data !== 8'hEE || bus.o_valid !== 1'b1) begin fails++; $display("FAIL wrap_held got v=%b d=%h exp v=1 d=ee", bus.o_valid, bus.o_data); end
        bus.i_ready = 1'b0;
        step();
        rst = 1'b1;
        bus.i_ready = 1'b1;
        #1;
        tests++; if (bus.o_ready !== 4'b0000) begin fails++; $display("FAIL mr_ready got=%b exp=0000", bus.o_ready); end
        step();
        rst = 1'b0;
        bus.i_valid = 4'b0000;
        tests++; if (bus.o_valid !== 1'b0 || bus.o_count !== 8'd0) begin fails++; $display("FAIL mr_state got v=%b cnt=%0d exp v=0 cnt=0", bus.o_valid, bus.o_count); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (bus.o_valid !== 1'b0 || bus.o_count !== 8'd0) begin fails++; $display("FAIL mr_after cyc=%0d got v=%b cnt=%0d exp v=0 cnt=0", i, bus.o_valid, bus.o_count); end
        end
    endtask

    initial begin
        bus.i_valid = 4'b0000;
        bus.i_data  = 32'h0;
        bus.i_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_backpressure();
        test_priority_stall();
        test_single();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
